// File: rtl/ram_fifo_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : ram_fifo_ctrl_if                                          |
// | Brief  : Stream and RAM-port bundle for the ram_fifo_ctrl block.   |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
interface ram_fifo_ctrl_if #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [D_WIDTH-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_data;
    logic               ram_write_enable;
    logic [A_WIDTH-1:0] ram_address_write;
    logic [D_WIDTH-1:0] ram_data_write;
    logic [A_WIDTH-1:0] ram_address_read;
    logic [D_WIDTH-1:0] ram_data_read;
    logic [A_WIDTH+1:0] count;

    // The controller is the slave; the surrounding system is the master.
    modport slave (
        input  in_valid, in_data, out_ready, ram_data_read,
        output in_ready, out_valid, out_data, ram_write_enable,
               ram_address_write, ram_data_write, ram_address_read, count
    );

    modport master (
        output in_valid, in_data, out_ready, ram_data_read,
        input  in_ready, out_valid, out_data, ram_write_enable,
               ram_address_write, ram_data_write, ram_address_read, count
    );
endinterface
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : ram_fifo_ctrl                                             |
// | Brief  : FIFO controller around a dual-port RAM with 1-cycle read  |
// |          latency and a 2-entry output buffer. Optional flush port  |
// |          enabled by RAM_FIFO_CTRL_FLUSH_EN.                        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module ram_fifo_ctrl #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef RAM_FIFO_CTRL_FLUSH_EN
    input  logic                 flush,
`endif
    ram_fifo_ctrl_if.slave       bus
);
    localparam int                 C_DEPTH     = 2 ** A_WIDTH;
    localparam logic [A_WIDTH:0]   C_DEPTH_CNT = (A_WIDTH + 1)'(C_DEPTH);
    localparam logic [A_WIDTH:0]   C_CNT_ONE   = (A_WIDTH + 1)'(1);
    localparam logic [A_WIDTH-1:0] C_PTR_ONE   = A_WIDTH'(1);

    logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [A_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [A_WIDTH:0]   ram_count_q, ram_count_d;
    logic               read_pending_q, read_pending_d;
    logic [1:0]         ob_count_q, ob_count_d;
    logic [D_WIDTH-1:0] ob0_q, ob0_d;
    logic [D_WIDTH-1:0] ob1_q, ob1_d;

    logic               w_in_ready;
    logic               w_push;
    logic               w_out_valid;
    logic               w_pop;
    logic [2:0]         w_ob_next;
    logic               w_issue;

`ifdef RAM_FIFO_CTRL_FLUSH_EN
    assign w_in_ready = !reset && !flush && (ram_count_q < C_DEPTH_CNT);
`else
    assign w_in_ready = !reset && (ram_count_q < C_DEPTH_CNT);
`endif
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_out_valid = (ob_count_q != 2'd0);
    assign w_pop       = w_out_valid && bus.out_ready;
    assign w_ob_next   = {1'b0, ob_count_q} + {2'b00, read_pending_q} - {2'b00, w_pop};
    // Only read when the buffer can absorb the word landing next cycle.
    assign w_issue     = (ram_count_q != '0) && (w_ob_next <= 3'd1);

    assign bus.in_ready          = w_in_ready;
    assign bus.ram_write_enable  = w_push;
    assign bus.ram_address_write = wr_ptr_q;
    assign bus.ram_data_write    = bus.in_data;
    assign bus.ram_address_read  = rd_ptr_q;
    assign bus.out_valid         = w_out_valid;
    assign bus.out_data          = ob0_q;
    assign bus.count             = {1'b0, ram_count_q}
                                 + {{(A_WIDTH + 1){1'b0}}, read_pending_q}
                                 + {{A_WIDTH{1'b0}}, ob_count_q};

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        ram_count_d    = ram_count_q;
        read_pending_d = w_issue;
        ob_count_d     = w_ob_next[1:0];
        ob0_d          = ob0_q;
        ob1_d          = ob1_q;

        if (w_push)  wr_ptr_d = wr_ptr_q + C_PTR_ONE;
        if (w_issue) rd_ptr_d = rd_ptr_q + C_PTR_ONE;

        case ({w_push, w_issue})
            2'b10:   ram_count_d = ram_count_q + C_CNT_ONE;
            2'b01:   ram_count_d = ram_count_q - C_CNT_ONE;
            default: ram_count_d = ram_count_q;
        endcase

        // ob0 is the head; a landing word goes to the first free slot after any pop.
        if (read_pending_q) begin
            if ((ob_count_q == 2'd0) || ((ob_count_q == 2'd1) && w_pop)) begin
                ob0_d = bus.ram_data_read;
            end else if (ob_count_q == 2'd1) begin
                ob1_d = bus.ram_data_read;
            end else begin
                ob0_d = ob1_q;
                ob1_d = bus.ram_data_read;
            end
        end else if (w_pop && (ob_count_q == 2'd2)) begin
            ob0_d = ob1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            ram_count_q    <= '0;
            read_pending_q <= 1'b0;
            ob_count_q     <= 2'd0;
            ob0_q          <= '0;
            ob1_q          <= '0;
`ifdef RAM_FIFO_CTRL_FLUSH_EN
        end else if (flush) begin
            // Buffer storage is left alone so out_data keeps its last value.
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            ram_count_q    <= '0;
            read_pending_q <= 1'b0;
            ob_count_q     <= 2'd0;
`endif
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            ram_count_q    <= ram_count_d;
            read_pending_q <= read_pending_d;
            ob_count_q     <= ob_count_d;
            ob0_q          <= ob0_d;
            ob1_q          <= ob1_d;
        end
    end
endmodule
`default_nettype wire
